// File: rtl/rv_pkg.sv
// Shared RV32I definitions: load funct3 codes and counter CSR addresses.
package rv_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

endpackage

// File: rtl/wb_ld_align.sv
// Sub-word load extraction with sign/zero extension and misalignment detect.
// Purely combinational, no flow control.
module wb_ld_align
  import rv_pkg::*;
(
  input  logic [2:0]  code,
  input  logic [1:0]  ofs,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{ofs, 3'b000} +: 8];
  assign half_sel = word[{ofs[1], 4'b0000} +: 16];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (code)
      LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: data = {24'd0, byte_sel};
      LD_H: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = ofs[0];
      end
      LD_HU: begin
        data       = {16'd0, half_sel};
        misaligned = ofs[0];
      end
      LD_W: begin
        data       = word;
        misaligned = (ofs != 2'b00);
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register-file write port (0-cycle), post-WB forward register and instret.
// Stall holds all state and suppresses writes; rst_pipe squashes the WB instruction.
module wb_stage
  import rv_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_ld_wb,
  input  logic [2:0]       ld_code_wb,
  input  logic [4:0]       rd_adr_wb,
  input  logic [31:0]      rd_data_wb,
  input  logic             wbk_rd_reg_wb,
  input  logic [31:0]      ld_data_wb,
  input  logic             retire_wb,
  input  logic             stall,
  input  logic             rst_pipe,
  output logic             wbk_we,
  output logic [4:0]       wbk_adr,
  output logic [31:0]      wbk_data,
  output logic             fw_en,
  output logic [4:0]       fw_adr,
  output logic [31:0]      fw_data,
  output logic             ld_misalign,
  output logic [CNT_W-1:0] instret,
  input  logic             instret_we_lo,
  input  logic             instret_we_hi,
  input  logic [31:0]      instret_wdata
);

  logic [31:0] ld_val;
  logic        mis;
  logic        ld_mis;
  logic        adv;

  wb_ld_align u_align (
    .code       (ld_code_wb),
    .ofs        (rd_data_wb[1:0]),
    .word       (ld_data_wb),
    .data       (ld_val),
    .misaligned (mis)
  );

  assign ld_mis   = cmd_ld_wb & mis;
  assign adv      = ~stall & ~rst_pipe;
  assign wbk_adr  = rd_adr_wb;
  assign wbk_data = cmd_ld_wb ? ld_val : rd_data_wb;
  // Misaligned loads are dropped from the register file but still retire.
  assign wbk_we   = ~rst & wbk_rd_reg_wb & (rd_adr_wb != 5'd0) & adv & ~ld_mis;

  always_ff @(posedge clk) begin
    if (rst || rst_pipe) begin
      fw_en   <= 1'b0;
      fw_adr  <= '0;
      fw_data <= '0;
    end else if (!stall) begin
      fw_en   <= wbk_we;
      fw_adr  <= wbk_adr;
      fw_data <= wbk_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ld_misalign <= 1'b0;
    else     ld_misalign <= ld_mis & adv;
  end

  // A CSR write wins over a coincident retire; that retire is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (instret_we_lo || instret_we_hi) begin
      if (instret_we_lo) instret[31:0]       <= instret_wdata;
      if (instret_we_hi) instret[CNT_W-1:32] <= instret_wdata[CNT_W-33:0];
    end else if (retire_wb && adv) begin
      instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the RV32I pipeline, directly downstream of the memory-access stage. It takes the WB-aligned command, result and raw load word and extracts/sign-extends sub-word loads. It drives the register-file write port, suppressing writes to x0, stalled writes and misaligned-load writes. It also holds a one-cycle post-write-back forwarding register for the EX bypass network and the 64-bit retired-instruction counter.

## Interface
- Parameters:
  - CNT_W, 64, width of retired-instruction counter
- Ports:
  - clk  in  1  system clock
  - rst  in  1  reset, synchronous, active-high
  - cmd_ld_wb  in  1  instruction in WB is a load
  - ld_code_wb  in  3  funct3 load code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are illegal
  - rd_adr_wb  in  5  destination register
  - rd_data_wb  in  32  ALU result; for loads, the effective address
  - wbk_rd_reg_wb  in  1  instruction writes rd
  - ld_data_wb  in  32  raw aligned load word from MA (already stall-corrected)
  - retire_wb  in  1  valid instruction occupies WB
  - stall  in  1  pipeline stall
  - rst_pipe  in  1  pipeline flush
  - wbk_we  out  1  register-file write enable
  - wbk_adr  out  5  register-file write address
  - wbk_data  out  32  register-file write data
  - fw_en  out  1  post-WB forward valid (registered)
  - fw_adr  out  5  post-WB forward address (registered)
  - fw_data  out  32  post-WB forward data (registered)
  - ld_misalign  out  1  misaligned-load pulse (registered)
  - instret  out  CNT_W  retired-instruction count
  - instret_we_lo  in  1  CSR write of instret[31:0]
  - instret_we_hi  in  1  CSR write of instret[63:32]
  - instret_wdata  in  32  CSR write data

## Operation
- Offset is `ofs = rd_data_wb[1:0]`.
- Load extraction:
  - LB/LBU: select byte `ofs`, then sign-extend or zero-extend.
  - LH/LHU: select half `ofs[1]`, then sign-extend or zero-extend.
  - LW: pass the word through.
  - Illegal code: extracted value = 0.
- Misalignment is defined as:
  - LH/LHU with `ofs[0]=1`
  - LW with `ofs!=0`
- `wbk_data = cmd_ld_wb ? extracted : rd_data_wb`.
- `wbk_adr = rd_adr_wb`.
- `wbk_we = wbk_rd_reg_wb & (rd_adr_wb!=0) & ~stall & ~rst_pipe & ~(cmd_ld_wb & misaligned)`.
- Forward register, at a clock edge:
  - If `rst` or `rst_pipe`: clear fw_en, fw_adr and fw_data.
  - Else if `~stall`: load `fw_en <= wbk_we`, `fw_adr <= wbk_adr`, `fw_data <= wbk_data`.
  - Else: hold.
- `ld_misalign` is registered. It equals `cmd_ld_wb & misaligned & ~stall & ~rst_pipe` and lasts one cycle.
- `instret` update priority:
  - `rst` clears to 0.
  - Otherwise a CSR write replaces the addressed half; both halves may be written in the same cycle.
  - Otherwise, if `retire_wb & ~stall & ~rst_pipe`, increment by 1 with wrap to 0 at all-ones. A misaligned load still retires.
  - A CSR write in the same cycle as a retire takes the written value; that retire is not counted.

## Timing
- wbk_we, wbk_adr and wbk_data are combinational from WB inputs. The register file commits them at the next clk edge: 0-cycle stage latency.
- fw_* and ld_misalign are valid one cycle after the WB cycle.
- instret reflects a retire one cycle after the WB cycle.
- Reset values, all 0: fw_en, fw_adr, fw_data, ld_misalign, instret.
- During reset, the combinational wbk_we is forced to 0.
- Stall held N cycles: exactly one register write and one count occur, in the first cycle with `stall=0`.
- `rst_pipe` coincident with a valid instruction: no write, no count, and fw_en cleared.
- `rst` asserted mid-stall: all state cleared at that edge; the next instruction after release behaves normally.
- Write to x0: wbk_we=0 and fw_en=0, but the instruction still counts.

## Structure
- Shared package `rv_pkg` holds:
  - load-code constants LD_B, LD_H, LD_W, LD_BU, LD_HU
  - the CSR address constants for instret/instreth
- One combinational sub-module, `wb_ld_align`:
  - inputs: code, ofs, word
  - outputs: data, misaligned
- Forward register and counter live in wb_stage.

## Test plan
- LB, `ld_data_wb=0x80FF7F01`, `rd_data_wb=0x100`-`0x103`, rd=5 → wbk_data = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80 respectively; LBU at offset 3 → 0x00000080.
- LH at offset 2 with word 0x8001_1234 → 0xFFFF8001; LHU at the same offset → 0x00008001; LH at offset 1 → wbk_we=0 and ld_misalign=1 next cycle.
- ALU op, rd=0, `rd_data_wb=0xDEADBEEF` → wbk_we=0, fw_en=0 next cycle, instret +1.
- `retire_wb=1` with stall held 3 cycles then released → a single wbk_we pulse and instret +1 total; fw_data equals wbk_data one cycle after release.
- instret=0xFFFFFFFF_FFFFFFFF plus a retire → wraps to 0; `instret_we_lo` with 0x12345678 coincident with a retire → instret[31:0]=0x12345678.
- `rst` asserted with instret=7 and fw_en=1 → all outputs 0 at the next edge; `rst_pipe` with a valid load → no write, no count.
